obi_rr_arbiter: RTL

//  N-requester to 1-target OBI arbiter for shared targets (flash, peripheral bus).
//  - Round-robin fair grant of the address phase.
//  - In-order response routing through an ID FIFO of outstanding transactions.
//  - Sits between the per-master demux outputs and one shared target port.

---
 rtl/obi_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/obi_rr_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/obi_pkg.sv
// Shared OBI definitions for the round-robin arbiter slice.
// Contents:
//   obi_req_t - address-phase fields {addr, we, be, wdata} at default widths
//   obi_rsp_t - response-phase fields {rvalid, rdata} at default widths
//   id_w()    - width of a requester index (ID_W), never less than 1 bit
package obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0]   addr;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_DATA_W-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_rsp_t;

    // ID_W helper: $clog2 collapses to 0 for a single entry, which is not a legal width.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Selects the first asserted request at or after i_ptr, wrapping NUM_REQ-1 -> 0.
// Ports:
//   i_req   [NUM_REQ]  request vector
//   i_ptr   [ID_W]     highest-priority index this cycle
//   o_gnt   [NUM_REQ]  one-hot winner (all zero when no request)
//   o_idx   [ID_W]     binary index of the winner
//   o_valid            any request present
module rr_arbiter
    import obi_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned ID_W   = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_valid
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// N-requester to 1-target OBI arbiter.
// Round-robin address-phase arbitration with address locking while the target
// stalls, and in-order response routing through an ID FIFO of outstanding
// transactions.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   req_i/gnt_o                        per-requester address handshake
//   addr_i/we_i/be_i/wdata_i           per-requester address-phase fields
//   rvalid_o/rdata_o                   per-requester response
//   shr_req_o/shr_gnt_i                shared target address handshake
//   shr_addr_o/we_o/be_o/wdata_o       shared target address-phase fields
//   shr_rvalid_i/shr_rdata_i           shared target response
//   err_o                              one-cycle pulse on protocol violation
module obi_rr_arbiter
    import obi_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    addr_i,
    input  logic [NUM_REQ-1:0]                we_i,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]  be_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic [NUM_REQ-1:0][DATA_W-1:0]    rdata_o,
    output logic                              shr_req_o,
    input  logic                              shr_gnt_i,
    output logic [ADDR_W-1:0]                 shr_addr_o,
    output logic                              shr_we_o,
    output logic [DATA_W/8-1:0]               shr_be_o,
    output logic [DATA_W-1:0]                 shr_wdata_o,
    input  logic                              shr_rvalid_i,
    input  logic [DATA_W-1:0]                 shr_rdata_i,
    output logic                              err_o
);

    localparam int unsigned ID_W  = id_w(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = id_w(MAX_OUTSTANDING);

    // State
    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_lock;
    logic [ID_W-1:0]  r_lock_id;
    logic [CNT_W-1:0] r_count;
    logic [ID_W-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_err;

    // Arbitration
    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_arb_valid;
    logic               w_locked;
    logic               w_lock_drop;
    logic [ID_W-1:0]    w_sel;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic               w_full;
    logic               w_empty;
    logic               w_shr_req;
    logic               w_hs;
    logic               w_pop;
    logic               w_spurious;
    logic [ID_W-1:0]    w_head;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_i),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // A locked requester that withdrew its request loses the lock this cycle.
    assign w_lock_drop = r_lock & ~req_i[r_lock_id];
    assign w_locked    = r_lock & req_i[r_lock_id];

    assign w_sel    = w_locked ? r_lock_id : w_arb_idx;
    assign w_sel_oh = w_locked ? (NUM_REQ'(1) << r_lock_id) : w_arb_gnt;

    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);

    // Full blocks the request even if a pop happens this cycle: keeps rvalid off the req path.
    assign w_shr_req = ~rst_i & w_arb_valid & ~w_full;
    assign w_hs      = w_shr_req & shr_gnt_i;

    assign w_head     = r_fifo[r_rd_ptr];
    assign w_pop      = ~rst_i & shr_rvalid_i & ~w_empty;
    assign w_spurious = shr_rvalid_i & w_empty;

    // Outputs
    assign shr_req_o   = w_shr_req;
    assign shr_addr_o  = w_shr_req ? addr_i[w_sel]  : '0;
    assign shr_we_o    = w_shr_req ? we_i[w_sel]    : 1'b0;
    assign shr_be_o    = w_shr_req ? be_i[w_sel]    : '0;
    assign shr_wdata_o = w_shr_req ? wdata_i[w_sel] : '0;

    assign gnt_o    = w_hs ? w_sel_oh : '0;
    assign rvalid_o = w_pop ? (NUM_REQ'(1) << w_head) : '0;
    assign rdata_o  = {NUM_REQ{shr_rdata_i}};
    assign err_o    = r_err;

    // Round-robin pointer and address lock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else begin
            if (w_hs) begin
                r_rr_ptr <= (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + ID_W'(1);
                r_lock   <= 1'b0;
            end else if (w_shr_req) begin
                // Target stalled: freeze the selection until it grants.
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end else if (w_lock_drop) begin
                r_lock <= 1'b0;
            end
        end
    end

    // ID FIFO of outstanding transactions
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_hs) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0
                                                                       : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0
                                                                       : r_rd_ptr + PTR_W'(1);
            end
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Protocol error pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_spurious | w_lock_drop;
        end
    end

endmodule
